// File: rtl/m72_tile_layer_p.sv
// m72_tile_layer_p: scrolling 8x8 tilemap layer with CPU VRAM port,
// frame-latched scroll, optional per-line row-scroll and ROM fetch.
module m72_tile_layer_p #(
    parameter int MAP_COLS_LOG2 = 6,
    parameter int MAP_ROWS_LOG2 = 6,
    parameter int BPP           = 4,
    parameter int CODE_W        = 14,
    parameter int ROWSCROLL     = 1
) (
    input  logic                  CLK_32M,
    input  logic                  RESET_N,
    input  logic                  CE_PIX,
    input  logic [8:0]            VE,
    input  logic [8:0]            HE,
    input  logic                  VBLANK,
    input  logic [15:0]           DIN,
    output logic [15:0]           DOUT,
    input  logic [19:0]           A,
    input  logic [1:0]            BYTE_SEL,
    input  logic                  WR,
    input  logic                  VSCK,
    input  logic                  HSCK,
    input  logic                  RSCK,
    input  logic                  ENABLED,
    output logic                  ROM_REQ,
    output logic [CODE_W+2:0]     ROM_ADDR,
    input  logic [8*BPP-1:0]      ROM_DATA,
    input  logic                  ROM_ACK,
    output logic [BPP-1:0]        BIT,
    output logic [3:0]            COL,
    output logic                  CP15,
    output logic                  CP8,
    output logic                  ROM_MISS
);

    localparam int AW  = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int SHW = MAP_COLS_LOG2 + 3;
    localparam int SVW = MAP_ROWS_LOG2 + 3;
    localparam int RW  = 8 * BPP;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_HAVE
    } fetch_e;

    // frame-latched scroll state
    logic       vblank_q;
    logic       vb_rise;
    logic [8:0] vs_pend_q, vs_pend_d;
    logic [8:0] hs_pend_q, hs_pend_d;
    logic       md_pend_q, md_pend_d;
    logic [8:0] vs_act_q, vs_act_d;
    logic [8:0] hs_act_q, hs_act_d;
    logic       md_act_q, md_act_d;
    logic       md_eff;

    // beam position after scroll
    logic [8:0]     sv9, sh9, hsel;
    logic [SVW-1:0] sv;
    logic [SHW-1:0] sh;
    logic [8:0]     rs_idx;
    logic [8:0]     rs_val;
    logic [2:0]     ph;

    // VRAM
    logic [7:0]    vram_lo [2**AW];
    logic [7:0]    vram_hi [2**AW];
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] map_addr;
    logic [AW-1:0] disp_addr;
    logic [15:0]   dout_q;
    logic [15:0]   disp_q;

    // fetch pipeline
    logic          ph3, ph4, ph5, ph7;
    logic [15:0]   tile_q;
    logic          tile_vld_q;
    logic [5:0]    attr_q;
    fetch_e        state_q, state_d;
    logic [CODE_W+2:0] rom_addr_q, rom_addr_d;
    logic [RW-1:0] rom_data_q, rom_data_d;
    logic          ack_now;
    logic          fetch_ok;
    logic          miss_now;
    logic [RW-1:0] load_word;

    // shifter and output stage
    logic [BPP-1:0][7:0] shf_q, shf_d;
    logic                hrev_q, hrev_d;
    logic [5:0]          stg_q, stg_d;
    logic [5:0]          out_q, out_d;
    logic [BPP-1:0]      bit_q, bit_d;
    logic                miss_q, miss_d;

    logic unused_ok;
    assign unused_ok = ^{A[19:AW+1]};

    assign vb_rise = VBLANK & ~vblank_q;
    assign md_eff  = (ROWSCROLL != 0) & md_act_q;

    assign sv9    = VE + vs_act_q;
    assign sv     = sv9[SVW-1:0];
    assign rs_idx = 9'(sv);
    assign hsel   = md_eff ? rs_val : hs_act_q;
    assign sh9    = HE + hsel;
    assign sh     = sh9[SHW-1:0];
    assign ph     = sh[2:0];

    // tile word lives at the cell address, its attribute in the next word
    assign map_addr  = {sv[SVW-1:3], sh[SHW-1:3]};
    assign disp_addr = map_addr + AW'(sh[2]);
    assign cpu_addr  = A[AW:1];

    // pending scroll register writes from the CPU strobes
    always_comb begin
        vs_pend_d = vs_pend_q;
        hs_pend_d = hs_pend_q;
        md_pend_d = md_pend_q;
        if (VSCK) begin
            if (A[0]) vs_pend_d[8]   = DIN[0];
            else      vs_pend_d[7:0] = DIN[7:0];
        end
        if (HSCK) begin
            if (A[0]) begin
                hs_pend_d[8] = DIN[0];
                md_pend_d    = DIN[15];
            end else begin
                hs_pend_d[7:0] = DIN[7:0];
            end
        end
    end

    // copy pending scroll to active at the start of vertical blank
    always_comb begin
        vs_act_d = vs_act_q;
        hs_act_d = hs_act_q;
        md_act_d = md_act_q;
        if (vb_rise) begin
            vs_act_d = vs_pend_q;
            hs_act_d = hs_pend_q;
            md_act_d = md_pend_q;
        end
    end

    // scroll registers
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            vblank_q  <= 1'b0;
            vs_pend_q <= '0;
            hs_pend_q <= '0;
            md_pend_q <= 1'b0;
            vs_act_q  <= '0;
            hs_act_q  <= '0;
            md_act_q  <= 1'b0;
        end else begin
            vblank_q  <= VBLANK;
            vs_pend_q <= vs_pend_d;
            hs_pend_q <= hs_pend_d;
            md_pend_q <= md_pend_d;
            vs_act_q  <= vs_act_d;
            hs_act_q  <= hs_act_d;
            md_act_q  <= md_act_d;
        end
    end

    if (ROWSCROLL != 0) begin : g_rs
        logic [8:0] rs_mem [512];
        // per-line H-scroll table, written straight from the CPU
        always_ff @(posedge CLK_32M) begin
            if (RSCK) rs_mem[A[9:1]] <= DIN[8:0];
        end
        assign rs_val = rs_mem[rs_idx];
    end else begin : g_nrs
        logic unused_rs;
        assign unused_rs = ^{RSCK, rs_idx};
        assign rs_val    = '0;
    end

    // byte-lane VRAM with CPU and display read ports
    always_ff @(posedge CLK_32M) begin
        if (WR && BYTE_SEL[0]) vram_lo[cpu_addr] <= DIN[7:0];
        if (WR && BYTE_SEL[1]) vram_hi[cpu_addr] <= DIN[15:8];
        dout_q <= {vram_hi[cpu_addr], vram_lo[cpu_addr]};
        disp_q <= {vram_hi[disp_addr], vram_lo[disp_addr]};
    end

    assign DOUT = dout_q;

    assign ph3 = CE_PIX && (ph == 3'd3);
    assign ph4 = CE_PIX && (ph == 3'd4) && tile_vld_q;
    assign ph5 = CE_PIX && (ph == 3'd5);
    assign ph7 = CE_PIX && (ph == 3'd7);

    // ROM fetch sequencing: request, wait for ack, hold data for load
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        ack_now    = (state_q == F_WAIT) && ROM_ACK;
        if (ack_now) begin
            state_d    = F_HAVE;
            rom_data_d = ROM_DATA;
        end
        if (ph4) begin
            state_d    = F_WAIT;
            rom_addr_d = {tile_q[CODE_W-1:0], sv[2:0] ^ {3{tile_q[15]}}};
        end
        if (ph7) state_d = F_IDLE;
    end

    assign fetch_ok  = (state_q == F_HAVE) || ack_now;
    assign load_word = (state_q == F_HAVE) ? rom_data_q : ROM_DATA;
    assign miss_now  = ph7 && (state_q == F_WAIT) && !ROM_ACK;

    // pixel shifter and output stage, advanced only on pixel enable
    always_comb begin
        shf_d  = shf_q;
        hrev_d = hrev_q;
        stg_d  = stg_q;
        out_d  = out_q;
        bit_d  = bit_q;
        miss_d = miss_q;
        if (vb_rise)  miss_d = 1'b0;
        if (miss_now) miss_d = 1'b1;
        if (CE_PIX) begin
            out_d = stg_q;
            for (int p = 0; p < BPP; p++) begin
                bit_d[p] = hrev_q ? shf_q[p][0] : shf_q[p][7];
                shf_d[p] = hrev_q ? (shf_q[p] >> 1) : (shf_q[p] << 1);
            end
            if (ph7) begin
                hrev_d = tile_q[14];
                stg_d  = attr_q;
                for (int p = 0; p < BPP; p++) begin
                    shf_d[p] = (fetch_ok && ENABLED) ?
                               load_word[8*p +: 8] : 8'h00;
                end
            end
        end
    end

    // fetch and pixel pipeline registers
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= F_IDLE;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            tile_q     <= '0;
            tile_vld_q <= 1'b0;
            attr_q     <= '0;
            shf_q      <= '0;
            hrev_q     <= 1'b0;
            stg_q      <= '0;
            out_q      <= '0;
            bit_q      <= '0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            if (ph3) begin
                tile_q     <= disp_q;
                tile_vld_q <= 1'b1;
            end
            if (ph5) attr_q <= {disp_q[7], disp_q[6], disp_q[3:0]};
            shf_q      <= shf_d;
            hrev_q     <= hrev_d;
            stg_q      <= stg_d;
            out_q      <= out_d;
            bit_q      <= bit_d;
            miss_q     <= miss_d;
        end
    end

    assign ROM_REQ  = (state_q == F_WAIT);
    assign ROM_ADDR = rom_addr_q;
    assign BIT      = bit_q;
    assign COL      = out_q[3:0];
    assign CP8      = out_q[4];
    assign CP15     = out_q[5];
    assign ROM_MISS = miss_q;

endmodule

// File: doc/m72_tile_layer_p.md
M72_TILE_LAYER_P -- requirements
Module: m72_tile_layer_p

Interface
Parameters: name, default, meaning
REQ-001 SHALL: MAP_COLS_LOG2, 6, log2 of tilemap columns; horizontal wrap is 2^(MAP_COLS_LOG2+3) px.
REQ-002 SHALL: MAP_ROWS_LOG2, 6, log2 of tilemap rows; vertical wrap is 2^(MAP_ROWS_LOG2+3) lines.
REQ-003 SHALL: BPP, 4, bitplanes per pixel; ROM word is 8*BPP bits.
REQ-004 SHALL: CODE_W, 14, tile code width.
REQ-005 SHALL: ROWSCROLL, 1, 1 = per-line H-scroll RAM is built; 0 = RSCK ignored, row mode forced off.
Ports: name, direction, width, meaning
REQ-006 SHALL: CLK_32M, in, 1, single clock; RESET_N, in, 1, asynchronous active-low reset.
REQ-007 SHALL: CE_PIX in 1 pixel enable; VE, HE in 9 each, beam counters; VBLANK in 1.
REQ-008 SHALL: DIN in 16; DOUT out 16, VRAM readback; A in 20; BYTE_SEL in 2; WR in 1, VRAM write.
REQ-009 SHALL: VSCK, HSCK, RSCK in 1 each: V-scroll, H-scroll/mode, row-scroll write strobes.
REQ-010 SHALL: ENABLED in 1; ROM_REQ out 1; ROM_ADDR out CODE_W+3; ROM_DATA in 8*BPP; ROM_ACK in 1.
REQ-011 SHALL: BIT out BPP; COL out 4; CP15, CP8 out 1; ROM_MISS out 1.

Function
REQ-012 SHALL: VRAM = two byte-lane RAMs of 2^(MAP_COLS_LOG2+MAP_ROWS_LOG2) words, CPU address A[MAP_COLS_LOG2+MAP_ROWS_LOG2:1], BYTE_SEL per lane, DOUT valid 1 cycle after address.
REQ-013 SHALL: VSCK/HSCK with A[0]=0 load pending scroll[7:0]=DIN[7:0]; with A[0]=1 load scroll[8]=DIN[0]; HSCK A[0]=1 also loads pending row mode=DIN[15].
REQ-014 SHALL: pending V/H scroll and mode copy to active registers on the cycle VBLANK is first sampled high; writes during same cycle land in pending, applied next VBLANK.
REQ-015 SHALL: RSCK writes DIN[8:0] to row-scroll RAM entry A[9:1] (512 x 9) immediately (not frame-latched).
REQ-016 SHALL: SV = VE + active V-scroll; SH = HE + (row mode ? rowscroll[SV] : active H-scroll); sums truncated to MAP_ROWS_LOG2+3 / MAP_COLS_LOG2+3 bits (wrap).
REQ-017 SHALL: map read address = {SV[MAP_ROWS_LOG2+2:3], SH[MAP_COLS_LOG2+2:3]}; tile word: [15]=VREV, [14]=HREV, [CODE_W-1:0]=code; attribute word low byte: [3:0]=COL, [6]=CP8, [7]=CP15.
REQ-018 SHALL: per tile, on CE_PIX with SH[2:0]: 3 latch tile word; 4 assert ROM_REQ, ROM_ADDR={code, SV[2:0]^{3{VREV}}}; 5 latch attribute; 7 load shifter and transfer attribute/HREV to output stage.
REQ-019 SHALL: ROM_REQ held until ROM_ACK; ROM_DATA captured on ACK cycle; ROM_REQ deasserts the cycle after ACK.
REQ-020 SHALL: if ACK absent at phase-7 load, shifter loads zero, ROM_REQ drops, late ACK ignored, ROM_MISS sets; ROM_MISS clears on VBLANK rising edge.
REQ-021 SHALL: shifter emits one pixel per CE_PIX, MSB first per plane; HREV selects LSB first; BIT = 0 when ENABLED=0 at load.
REQ-022 SHALL: BIT, COL, CP15, CP8 change only on CE_PIX; latency from phase-7 load to first pixel = 1 CE_PIX.
REQ-023 SHALL: ROM_ACK with no outstanding request is ignored.

Reset
REQ-024 SHALL: RESET_N low forces scroll (pending/active), mode, shifter, BIT, COL, CP15, CP8, ROM_REQ, ROM_MISS to 0 immediately; RAM contents untouched.
REQ-025 SHALL: reset mid-request drops ROM_REQ; first fetch after release starts at next SH[2:0]=3.

Verification
REQ-026 SHALL: VRAM word 0 = 0x0005, ROM code 5 row 0 = 0xF0F0F0F0 (BPP=4), scroll 0 -> pixels 0-3 BIT=0xF, 4-7 BIT=0x0.
REQ-027 SHALL: same tile with HREV=1 -> pixels 0-3 BIT=0x0, 4-7 BIT=0xF.
REQ-028 SHALL: HSCK write 0x008 mid-frame -> no shift until next VBLANK, then map column 1 at HE=0.
REQ-029 SHALL: row mode on, rowscroll[10]=0x1F8 -> line SV=10 shows column 63 at HE=0, other lines unaffected.
REQ-030 SHALL: ROM_ACK withheld past phase 7 -> 8 pixels BIT=0, ROM_MISS=1 until VBLANK rising edge.
REQ-031 SHALL: RESET_N pulsed while ROM_REQ=1 -> ROM_REQ=0 same cycle, all outputs 0, normal fetch resumes.
